smc_ahb_mcs_if: RTL and testbench
=================================

Name: smc_ahb_mcs_if

Overview:
- Parametrised successor AHB-lite slave front end for the Static Memory Controller.
- Decodes up to NUM_CS external banks from the address, registers the address phase and holds it stable for the SMC state machine.
- Stretches hready until the SMC reports completion.
- Generates two-cycle AHB ERROR responses for misaligned, out-of-range or disabled-bank accesses.
- Sits between the AHB interconnect and the SMC core (state machine and MAC).

Parameters:
- AW, 32, address width.
- DW, 32, data width; 32 or 64.
- NUM_CS, 4, number of chip selects; 1..8.
- BANK_SHIFT, 24, LSB position of the bank index field in haddr.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- hclk  in  1  AHB system clock.
- n_sys_reset  in  1  system reset, asynchronous, active low.
- hsel  in  1  slave select.
- haddr  in  AW  AHB address.
- htrans  in  2  transfer type.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hwdata  in  DW  write data.
- hready  in  1  muxed bus ready.
- bank_en  in  NUM_CS  per-bank enable from config registers.
- smc_idle  in  1  SMC state machine idle.
- smc_done  in  1  last cycle of an SMC access.
- mac_done  in  1  all MAC sub-transfers complete.
- read_data  in  DW  data from the external bus path.
- smc_hrdata  out  DW  read data to AHB.
- smc_hready  out  1  slave ready.
- smc_hresp  out  2  AHB response.
- smc_valid  out  1  combinational valid-access acknowledge.
- new_access  out  1  one-cycle start strobe to the SMC.
- addr  out  AW  registered access address.
- cs  out  NUM_CS  one-hot registered chip select.
- xfer_size  out  2  registered hsize[1:0].
- n_read  out  1  registered hwrite; 0 = read.
- write_data  out  DW  write data to the external bus.

Behaviour:
- Clock and reset: one clock, hclk. Reset n_sys_reset is asynchronous, active low.
- Reset values: state IDLE; smc_hready=1; smc_hresp=OKAY; cs=0; addr=0; xfer_size=0; n_read=0; new_access=0; write_data=0.
- Bank and validity decode:
  - bank = haddr[BANK_SHIFT +: clog2(NUM_CS)]. For NUM_CS=1 the bank is always 0.
  - A valid address phase (vap) is: hsel & hready & htrans in {NONSEQ, SEQ}.
- Error conditions (err), each evaluated during vap:
  - half access with haddr[0] set;
  - word access with haddr[1:0] nonzero;
  - dword access with haddr[2:0] nonzero or DW=32;
  - hsize > dword;
  - bank >= NUM_CS;
  - bank_en[bank]=0.
- smc_valid = vap & ~err. It is combinational and the same cycle as the address phase.
- States: IDLE, ACCESS, ERR1, ERR2.
  - IDLE: vap & ~err -> ACCESS; capture addr, xfer_size, n_read, cs=onehot(bank). vap & err -> ERR1. Otherwise stay. smc_hready=1, smc_hresp=OKAY.
  - ACCESS:
    - new_access=1 in the first cycle only.
    - write_data is combinational hwdata in the first cycle and the held register thereafter.
    - smc_hready = smc_done & mac_done. When it is 1, a back-to-back vap is sampled: ~err -> ACCESS with new capture; err -> ERR1; none -> IDLE with cs cleared.
  - ERR1: smc_hready=0, smc_hresp=ERROR, unconditionally -> ERR2.
  - ERR2: smc_hready=1, smc_hresp=ERROR. A vap here is handled exactly as in IDLE.
- IDLE or BUSY with hsel=1: zero-wait OKAY, no state change.
- smc_hrdata = read_data (combinational).
- Signals held stable while ACCESS has smc_hready=0: addr, cs, xfer_size, n_read.
- A change of bank_en during ACCESS does not abort the current access.
- Reset asserted mid-access: return to IDLE at once, cs=0, smc_hready=1. The SMC core is reset by the same net.

Optional Feature:
- Macro SMC_AHB_TIMEOUT_EN.
- With it defined:
  - A counter runs in ACCESS and clears on every entry to ACCESS.
  - When it reaches TIMEOUT_CYCLES-1 without smc_done & mac_done: go to ERR1, drop cs, and finish with the two-cycle ERROR response.
- Without it: ACCESS waits indefinitely. No counter logic is present.

Decomposition:
- Package smc_ahb_pkg holds:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE codes byte/half/word/dword;
  - HRESP codes OKAY/ERROR;
  - the state enum.
- One natural sub-module: smc_ahb_err_dec. It is combinational bank decode plus error detection, producing bank, err and smc_valid.

Test Plan:
- Word read to bank 1, addr 0x0100_0010, bank_en=4'b1111, smc_done & mac_done after 3 cycles:
  - new_access for 1 cycle; cs=4'b0010;
  - smc_hready low 3 cycles; hrdata = read_data; OKAY.
- Half write to addr 0x0000_0001:
  - no new_access;
  - ERR1 (hready=0, ERROR) then ERR2 (hready=1, ERROR); then IDLE with OKAY.
- Write to bank 2 with bank_en=4'b1011: ERROR response pair; cs remains 0.
- Back-to-back NONSEQ write then read to bank 0, second address phase in the done cycle:
  - second new_access the cycle after done;
  - write_data equals the first hwdata through the first access.
- Reset pulsed during ACCESS: cs=0, smc_hready=1, smc_hresp=OKAY immediately.
- SMC_AHB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mac_done held low: ERROR pair starts after 8 ACCESS cycles.

Source files
------------

// File: rtl/smc_ahb_pkg.sv
// Shared AHB-lite encodings and the front-end state type for the SMC AHB slave.
package smc_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

endpackage

// File: rtl/smc_ahb_err_dec.sv
// Combinational bank decode and access-error detection for the SMC AHB front end.
module smc_ahb_err_dec
  import smc_ahb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NUM_CS     = 4,
  parameter int BANK_SHIFT = 24
) (
  input  logic              hsel,
  input  logic              hready,
  input  logic [AW-1:0]     haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [NUM_CS-1:0] bank_en,
  output logic [2:0]        bank,
  output logic              err,
  output logic              smc_valid
);

  localparam int BW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic vap;
  logic misaligned;
  logic en_ok;
  logic bad;
  logic unused_ok;

  generate
    if (NUM_CS > 1) begin : g_multi
      assign bank = 3'(haddr[BANK_SHIFT +: BW]);
    end else begin : g_single
      assign bank = '0;
    end
  endgenerate

  assign vap = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));

  // A bank index at or above NUM_CS never matches, so it reads as disabled.
  always_comb begin
    en_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (bank == 3'(i)) en_ok = bank_en[i];
    end
    case (hsize)
      HSIZE_BYTE:  misaligned = 1'b0;
      HSIZE_HALF:  misaligned = haddr[0];
      HSIZE_WORD:  misaligned = |haddr[1:0];
      HSIZE_DWORD: misaligned = (|haddr[2:0]) | (DW == 32);
      default:     misaligned = 1'b1;
    endcase
    bad = misaligned | ~en_ok;
  end

  assign err       = vap & bad;
  assign smc_valid = vap & ~bad;
  assign unused_ok = ^haddr;

endmodule

// File: rtl/smc_ahb_mcs_if.sv
// AHB-lite slave front end for the Static Memory Controller.
// Optional access watchdog enabled by defining SMC_AHB_TIMEOUT_EN.
module smc_ahb_mcs_if
  import smc_ahb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int NUM_CS         = 4,
  parameter int BANK_SHIFT     = 24,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              hclk,
  input  logic              n_sys_reset,
  input  logic              hsel,
  input  logic [AW-1:0]     haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DW-1:0]     hwdata,
  input  logic              hready,
  input  logic [NUM_CS-1:0] bank_en,
  input  logic              smc_idle,
  input  logic              smc_done,
  input  logic              mac_done,
  input  logic [DW-1:0]     read_data,
  output logic [DW-1:0]     smc_hrdata,
  output logic              smc_hready,
  output logic [1:0]        smc_hresp,
  output logic              smc_valid,
  output logic              new_access,
  output logic [AW-1:0]     addr,
  output logic [NUM_CS-1:0] cs,
  output logic [1:0]        xfer_size,
  output logic              n_read,
  output logic [DW-1:0]     write_data
);

  state_t              state;
  logic [2:0]          bank;
  logic                err;
  logic                done;
  logic                sample;
  logic [NUM_CS-1:0]   cs_dec;
  logic [DW-1:0]       wdata_q;
  logic [1:0]          hresp_q;
  logic                unused_ok;

  smc_ahb_err_dec #(
    .AW         (AW),
    .DW         (DW),
    .NUM_CS     (NUM_CS),
    .BANK_SHIFT (BANK_SHIFT)
  ) u_err_dec (
    .hsel      (hsel),
    .hready    (hready),
    .haddr     (haddr),
    .htrans    (htrans),
    .hsize     (hsize),
    .bank_en   (bank_en),
    .bank      (bank),
    .err       (err),
    .smc_valid (smc_valid)
  );

  always_comb begin
    cs_dec = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (bank == 3'(i)) cs_dec[i] = 1'b1;
    end
  end

  assign done   = smc_done & mac_done;
  // A new address phase is accepted whenever this slave is signalling ready.
  assign sample = (state == S_IDLE) | (state == S_ERR2) | ((state == S_ACCESS) & done);

  assign smc_hready = (state == S_ACCESS) ? done : (state != S_ERR1);
  assign smc_hresp  = hresp_q;
  assign smc_hrdata = read_data;
  assign write_data = new_access ? hwdata : wdata_q;

`ifdef SMC_AHB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      state      <= S_IDLE;
      hresp_q    <= HRESP_OKAY;
      cs         <= '0;
      addr       <= '0;
      xfer_size  <= '0;
      n_read     <= 1'b0;
      new_access <= 1'b0;
      wdata_q    <= '0;
`ifdef SMC_AHB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      new_access <= 1'b0;
      if (new_access) wdata_q <= hwdata;
`ifdef SMC_AHB_TIMEOUT_EN
      if (state == S_ACCESS) cnt <= cnt + 1'b1;
`endif
      if (sample) begin
        if (smc_valid) begin
          state      <= S_ACCESS;
          hresp_q    <= HRESP_OKAY;
          addr       <= haddr;
          xfer_size  <= hsize[1:0];
          n_read     <= hwrite;
          cs         <= cs_dec;
          new_access <= 1'b1;
`ifdef SMC_AHB_TIMEOUT_EN
          cnt        <= '0;
`endif
        end else if (err) begin
          state   <= S_ERR1;
          hresp_q <= HRESP_ERROR;
          cs      <= '0;
        end else begin
          state   <= S_IDLE;
          hresp_q <= HRESP_OKAY;
          cs      <= '0;
        end
      end else if (state == S_ERR1) begin
        state <= S_ERR2;
`ifdef SMC_AHB_TIMEOUT_EN
      end else if ((state == S_ACCESS) && (cnt == CW'(TIMEOUT_CYCLES - 1))) begin
        state   <= S_ERR1;
        hresp_q <= HRESP_ERROR;
        cs      <= '0;
`endif
      end
    end
  end

  assign unused_ok = smc_idle ^ TIMEOUT_CYCLES[0];

endmodule

// File: tb/tb_smc_ahb_mcs_if.sv
// Self-checking bench for smc_ahb_mcs_if: directed cases plus randomized transfers against a transaction model.
// Define SMC_AHB_TIMEOUT_EN to also run the watchdog case.
module tb_smc_ahb_mcs_if;

  localparam int DW = 32;

  logic        hclk = 1'b0;
  logic        n_sys_reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [3:0]  bank_en;
  logic        smc_idle;
  logic        smc_done;
  logic        mac_done;
  logic [31:0] read_data;
  logic [31:0] smc_hrdata;
  logic        smc_hready;
  logic [1:0]  smc_hresp;
  logic        smc_valid;
  logic        new_access;
  logic [31:0] addr;
  logic [3:0]  cs;
  logic [1:0]  xfer_size;
  logic        n_read;
  logic [31:0] write_data;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  smc_ahb_mcs_if #(
    .AW             (32),
    .DW             (DW),
    .NUM_CS         (4),
    .BANK_SHIFT     (24),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .hclk        (hclk),
    .n_sys_reset (n_sys_reset),
    .hsel        (hsel),
    .haddr       (haddr),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hwdata      (hwdata),
    .hready      (hready),
    .bank_en     (bank_en),
    .smc_idle    (smc_idle),
    .smc_done    (smc_done),
    .mac_done    (mac_done),
    .read_data   (read_data),
    .smc_hrdata  (smc_hrdata),
    .smc_hready  (smc_hready),
    .smc_hresp   (smc_hresp),
    .smc_valid   (smc_valid),
    .new_access  (new_access),
    .addr        (addr),
    .cs          (cs),
    .xfer_size   (xfer_size),
    .n_read      (n_read),
    .write_data  (write_data)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Transaction-level model: an access is rejected if misaligned for its size,
  // larger than the bus, or aimed at a disabled bank.
  function automatic bit model_err(logic [31:0] a, logic [2:0] sz, logic [3:0] ben);
    int unsigned bytes;
    int unsigned bank;
    if (sz > 3) return 1'b1;
    bytes = 1 << sz;
    if (bytes * 8 > DW) return 1'b1;
    if (a % bytes != 0) return 1'b1;
    bank = (a / (1 << 24)) % 4;
    return !ben[bank];
  endfunction

  function automatic logic [3:0] model_cs(logic [31:0] a);
    return 4'(1 << ((a / (1 << 24)) % 4));
  endfunction

  task automatic err_pair();
    smc_done = 1'b0; mac_done = 1'b0; hready = 1'b0;
    #1;
    total++; if (smc_hready !== 1'b0) begin bad++; $error("FAIL err1_ready: %0h", smc_hready); end
    total++; if (smc_hresp !== 2'b01) begin bad++; $error("FAIL err1_resp: %0h", smc_hresp); end
    total++; if (new_access !== 1'b0) begin bad++; $error("FAIL err1_newacc: %0h", new_access); end
    total++; if (cs !== 4'b0000) begin bad++; $error("FAIL err1_cs: %0h", cs); end
    tick();
    hready = 1'b1;
    #1;
    total++; if (smc_hready !== 1'b1) begin bad++; $error("FAIL err2_ready: %0h", smc_hready); end
    total++; if (smc_hresp !== 2'b01) begin bad++; $error("FAIL err2_resp: %0h", smc_hresp); end
    total++; if (cs !== 4'b0000) begin bad++; $error("FAIL err2_cs: %0h", cs); end
    tick();
  endtask

  task automatic idle_check();
    hsel = 1'b0; htrans = 2'b00; hready = 1'b1; smc_done = 1'b0; mac_done = 1'b0;
    #1;
    total++; if (smc_hready !== 1'b1) begin bad++; $error("FAIL idle_ready: %0h", smc_hready); end
    total++; if (smc_hresp !== 2'b00) begin bad++; $error("FAIL idle_resp: %0h", smc_hresp); end
    total++; if (cs !== 4'b0000) begin bad++; $error("FAIL idle_cs: %0h", cs); end
  endtask

  task automatic run_xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                          input logic [3:0] ben, input logic [3:0] ben_mid, input int unsigned waits);
    logic [31:0] wd;
    bit          e;
    e  = model_err(a, sz, ben);
    wd = $urandom;
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; haddr = a; hwrite = w; hsize = sz;
    bank_en = ben; smc_done = 1'b0; mac_done = 1'b0;
    #1;
    total++; if (smc_valid !== 1'(!e)) begin bad++; $error("FAIL aphase_valid: %0h", smc_valid); end
    total++; if (smc_hready !== 1'b1) begin bad++; $error("FAIL aphase_ready: %0h", smc_hready); end
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = wd; haddr = $urandom; bank_en = ben_mid;
    if (e) begin
      err_pair();
    end else begin
      for (int unsigned k = 0; k <= waits; k++) begin
        smc_done = (k == waits); mac_done = (k == waits); hready = (k == waits);
        read_data = $urandom;
        if (k > 0) hwdata = $urandom;
        #1;
        total++; if (new_access !== 1'(k == 0)) begin bad++; $error("FAIL acc_newacc: %0h", new_access); end
        total++; if (cs !== model_cs(a)) begin bad++; $error("FAIL acc_cs: %0h", cs); end
        total++; if (addr !== a) begin bad++; $error("FAIL acc_addr: %0h", addr); end
        total++; if (n_read !== 1'(w)) begin bad++; $error("FAIL acc_nread: %0h", n_read); end
        total++; if (xfer_size !== sz[1:0]) begin bad++; $error("FAIL acc_size: %0h", xfer_size); end
        total++; if (smc_hready !== 1'(k == waits)) begin bad++; $error("FAIL acc_ready: %0h", smc_hready); end
        total++; if (smc_hresp !== 2'b00) begin bad++; $error("FAIL acc_resp: %0h", smc_hresp); end
        total++; if (write_data !== wd) begin bad++; $error("FAIL acc_wdata: %0h", write_data); end
        total++; if (smc_hrdata !== read_data) begin bad++; $error("FAIL acc_rdata: %0h", smc_hrdata); end
        tick();
      end
    end
    idle_check();
  endtask

  initial begin
    logic [31:0] wd1;
    logic [31:0] ra;
    logic [2:0]  rs;
    logic [3:0]  rb;
    n_sys_reset = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0; hready = 1'b1; bank_en = 4'hF; smc_idle = 1'b1;
    smc_done = 1'b0; mac_done = 1'b0; read_data = '0;
    #12;
    total++; if (smc_hready !== 1'b1) begin bad++; $error("FAIL rst_ready: %0h", smc_hready); end
    total++; if (smc_hresp !== 2'b00) begin bad++; $error("FAIL rst_resp: %0h", smc_hresp); end
    total++; if (cs !== 4'b0000) begin bad++; $error("FAIL rst_cs: %0h", cs); end
    total++; if (addr !== 32'h0) begin bad++; $error("FAIL rst_addr: %0h", addr); end
    total++; if (new_access !== 1'b0) begin bad++; $error("FAIL rst_newacc: %0h", new_access); end
    total++; if (write_data !== 32'h0) begin bad++; $error("FAIL rst_wdata: %0h", write_data); end
    total++; if (xfer_size !== 2'b00) begin bad++; $error("FAIL rst_size: %0h", xfer_size); end
    total++; if (n_read !== 1'b0) begin bad++; $error("FAIL rst_nread: %0h", n_read); end
    @(negedge hclk);
    n_sys_reset = 1'b1;
    tick();

    run_xfer(32'h0100_0010, 1'b0, 3'b010, 4'hF, 4'hF, 3);
    run_xfer(32'h0000_0001, 1'b1, 3'b001, 4'hF, 4'hF, 0);
    run_xfer(32'h0200_0000, 1'b1, 3'b010, 4'b1011, 4'b1011, 1);
    run_xfer(32'h0300_0008, 1'b0, 3'b011, 4'hF, 4'hF, 0);
    run_xfer(32'h0300_0000, 1'b0, 3'b100, 4'hF, 4'hF, 0);
    run_xfer(32'h0300_0003, 1'b1, 3'b000, 4'hF, 4'hF, 2);
    run_xfer(32'h0200_0004, 1'b1, 3'b010, 4'hF, 4'h0, 2);

    hsel = 1'b1; htrans = 2'b01; hready = 1'b1; haddr = 32'h0000_0001; hsize = 3'b001;
    #1;
    total++; if (smc_valid !== 1'b0) begin bad++; $error("FAIL busy_valid: %0h", smc_valid); end
    total++; if (smc_hready !== 1'b1) begin bad++; $error("FAIL busy_ready: %0h", smc_hready); end
    tick();
    total++; if (new_access !== 1'b0) begin bad++; $error("FAIL busy_newacc: %0h", new_access); end
    idle_check();

    wd1 = $urandom;
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; haddr = 32'h0000_0040; hwrite = 1'b1;
    hsize = 3'b010; bank_en = 4'hF;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = wd1; hready = 1'b0;
    #1;
    total++; if (new_access !== 1'b1) begin bad++; $error("FAIL b2b_first_newacc: %0h", new_access); end
    total++; if (write_data !== wd1) begin bad++; $error("FAIL b2b_first_wdata: %0h", write_data); end
    tick();
    hwdata = $urandom;
    #1;
    total++; if (write_data !== wd1) begin bad++; $error("FAIL b2b_hold_wdata: %0h", write_data); end
    total++; if (smc_hready !== 1'b0) begin bad++; $error("FAIL b2b_hold_ready: %0h", smc_hready); end
    tick();
    smc_done = 1'b1; mac_done = 1'b1; hready = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0080; hwrite = 1'b0;
    #1;
    total++; if (smc_valid !== 1'b1) begin bad++; $error("FAIL b2b_done_valid: %0h", smc_valid); end
    total++; if (smc_hready !== 1'b1) begin bad++; $error("FAIL b2b_done_ready: %0h", smc_hready); end
    total++; if (write_data !== wd1) begin bad++; $error("FAIL b2b_done_wdata: %0h", write_data); end
    total++; if (addr !== 32'h0000_0040) begin bad++; $error("FAIL b2b_done_addr: %0h", addr); end
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = $urandom;
    #1;
    total++; if (new_access !== 1'b1) begin bad++; $error("FAIL b2b_second_newacc: %0h", new_access); end
    total++; if (addr !== 32'h0000_0080) begin bad++; $error("FAIL b2b_second_addr: %0h", addr); end
    total++; if (n_read !== 1'b0) begin bad++; $error("FAIL b2b_second_nread: %0h", n_read); end
    total++; if (cs !== 4'b0001) begin bad++; $error("FAIL b2b_second_cs: %0h", cs); end
    tick();
    idle_check();

    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; haddr = 32'h0100_0000; hwrite = 1'b0; hsize = 3'b010;
    tick();
    hsel = 1'b0; htrans = 2'b00; hready = 1'b0; smc_done = 1'b0; mac_done = 1'b0;
    #1;
    total++; if (cs !== 4'b0010) begin bad++; $error("FAIL prerst_cs: %0h", cs); end
    total++; if (smc_hready !== 1'b0) begin bad++; $error("FAIL prerst_ready: %0h", smc_hready); end
    #1 n_sys_reset = 1'b0;
    #1;
    total++; if (cs !== 4'b0000) begin bad++; $error("FAIL midrst_cs: %0h", cs); end
    total++; if (smc_hready !== 1'b1) begin bad++; $error("FAIL midrst_ready: %0h", smc_hready); end
    total++; if (smc_hresp !== 2'b00) begin bad++; $error("FAIL midrst_resp: %0h", smc_hresp); end
    total++; if (new_access !== 1'b0) begin bad++; $error("FAIL midrst_newacc: %0h", new_access); end
    @(negedge hclk);
    n_sys_reset = 1'b1;
    tick();
    idle_check();

`ifdef SMC_AHB_TIMEOUT_EN
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; haddr = 32'h0000_0000; hwrite = 1'b1; hsize = 3'b010;
    tick();
    hsel = 1'b0; htrans = 2'b00; hready = 1'b0; smc_done = 1'b1; mac_done = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      #1;
      total++; if (smc_hready !== 1'b0) begin bad++; $error("FAIL to_ready: %0h", smc_hready); end
      total++; if (smc_hresp !== 2'b00) begin bad++; $error("FAIL to_resp: %0h", smc_hresp); end
      total++; if (cs !== 4'b0001) begin bad++; $error("FAIL to_cs: %0h", cs); end
      tick();
    end
    err_pair();
    idle_check();
`endif

    for (int unsigned n = 0; n < 60; n++) begin
      rs = 3'($urandom_range(0, 4));
      ra = ($urandom_range(0, 3) << 24) | ($urandom & 32'h00FF_FFFF);
      if ($urandom_range(0, 3) != 0 && rs < 3) ra = ra & ~((32'd1 << rs) - 1);
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      run_xfer(ra, 1'($urandom), rs, rb, 4'($urandom), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
